// File: rtl/mem_read_client.sv
// Burst read initiator: issues credit-limited word requests to the memory controller
// and buffers the returned words in a small FIFO drained through a valid/ready stream.
module mem_read_client #(
  parameter int unsigned MEM_BANDWIDTH = 4,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned LEN_W         = 10,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LEN_W-1:0]           num_words,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_req_addr,
  input  logic                       mem_ack,
  input  logic [MEM_BANDWIDTH*8-1:0] mem_data,
  input  logic                       mem_data_valid,
  output logic [MEM_BANDWIDTH*8-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       protocol_err
);
  localparam int unsigned DATA_W = MEM_BANDWIDTH * 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    total_q, total_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic                err_q, err_d;
  logic                busy_q, done_q, req_q, req_d, valid_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SUM_W-1:0]    credit_sum;
  logic                ack, push, pop;

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_req      = req_q;
  assign mem_req_addr = addr_q;
  assign out_valid    = valid_q;
  assign out_data     = mem_q[rd_ptr_q];
  assign protocol_err = err_q;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    total_d  = total_q;
    issued_d = issued_q;
    err_d    = err_q;
    ack      = req_q & mem_ack;
    push     = mem_data_valid && (outst_q != '0) &&
               ((state_q == S_REQ) || (state_q == S_DRAIN));
    pop      = valid_q & out_ready;
    outst_d  = outst_q + CNT_W'(ack) - CNT_W'(push);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_words != '0) begin
            base_d   = base_addr;
            total_d  = num_words;
            issued_d = '0;
            state_d  = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        issued_d = issued_q + LEN_W'(ack);
        if (issued_d == total_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((outst_d == '0) && (cnt_d == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (mem_data_valid && !push) err_d = 1'b1;

    // Credit counts both in-flight requests and words already buffered
    credit_sum = SUM_W'(outst_d) + SUM_W'(cnt_d);
    req_d  = (state_d == S_REQ) && (issued_d < total_d) &&
             (credit_sum < SUM_W'(FIFO_DEPTH));
    addr_d = addr_q;
    if (state_d == S_REQ) addr_d = base_d + ADDR_W'(issued_d);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      total_q  <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      total_q  <= total_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= (cnt_d != '0);
    end
  end

  // Return FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= mem_data;
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
    end
  end
endmodule

// File: tb/tb_mem_read_client.sv
// Directed bench for mem_read_client: table of burst scenarios driven by a
// cycle-stepped controller/consumer model, plus error and reset sequences.
module tb_mem_read_client;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 10;
  localparam int unsigned DW = 32;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          busy, done, mem_req;
  logic [AW-1:0] mem_req_addr;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_data_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          protocol_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] base;
    int          num;
    int          ack_dly;
    int          ret_lat;
    int          ready_mode;  // 0 always, 1 stalled until cycle 20, 2 alternating
    bit          poke;        // pulse start again mid-burst
    int          exp_done;    // cycle (after start) where done is seen; 0 = unchecked
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } ret_t;

  vec_t vecs[8];
  ret_t retq[$];

  mem_read_client dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_req_addr(mem_req_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .mem_data_valid(mem_data_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_addr"}, 64'(mem_req_addr), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_err"}, 64'(protocol_err), 64'd0);
  endtask

  task automatic run_burst(input vec_t v);
    int cyc, n_ack, n_pop, done_cyc, wait_c, max_fly;
    bit req_seen, r;
    ret_t rr;
    retq.delete();
    cyc = 0; n_ack = 0; n_pop = 0; done_cyc = -1; wait_c = 0; max_fly = 0;
    req_seen = 1'b0;
    base_addr = v.base;
    num_words = LW'(v.num);
    start = 1'b1;
    while (done_cyc < 0 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start = v.poke && (cyc == 2);
      if (start) begin
        base_addr = 16'h1234;
        num_words = 10'd5;
      end
      if (cyc == 1) begin
        chk("err_cleared_on_start", 64'(protocol_err), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);
      end
      if (v.ready_mode == 1 && cyc == 20) begin
        chk("stall_acks", 64'(n_ack), 64'(DEPTH));
        chk("stall_req_low", 64'(mem_req), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_head", 64'(out_data), 64'(word_of(v.base)));
      end
      if (done) done_cyc = cyc;

      mem_ack = 1'b0;
      mem_data_valid = 1'b0;
      mem_data = '0;
      if (retq.size() > 0 && retq[0].due <= cyc) begin
        rr = retq.pop_front();
        mem_data_valid = 1'b1;
        mem_data = word_of(rr.addr);
      end
      if (mem_req) begin
        req_seen = 1'b1;
        chk("req_addr", 64'(mem_req_addr), 64'(16'(v.base + 16'(n_ack))));
        if (wait_c >= v.ack_dly) begin
          mem_ack = 1'b1;
          retq.push_back('{cyc + v.ret_lat, mem_req_addr});
          n_ack++;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end else begin
        wait_c = 0;
      end

      case (v.ready_mode)
        0:       r = 1'b1;
        1:       r = (cyc > 20);
        default: r = cyc[0];
      endcase
      out_ready = r;
      if (out_valid && r) begin
        chk("out_word", 64'(out_data), 64'(word_of(16'(v.base + 16'(n_pop)))));
        n_pop++;
      end
      if (n_ack - n_pop > max_fly) max_fly = n_ack - n_pop;
    end

    if (done_cyc < 0) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      if (v.exp_done != 0) chk("done_latency", 64'(done_cyc), 64'(v.exp_done));
      chk("ack_count", 64'(n_ack), 64'(v.num));
      chk("pop_count", 64'(n_pop), 64'(v.num));
      chk("credit_max", 64'(max_fly <= DEPTH), 64'd1);
      if (v.num == 0) chk("req_never", 64'(req_seen), 64'd0);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    mem_data_valid = 1'b0;
    start = 1'b0;
    chk("done_single_pulse", 64'(done), 64'd0);
    chk("busy_low_after", 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 3, 0, 1, 0, 1'b0, 6};
    vecs[1] = '{16'h0100, 8, 0, 1, 1, 1'b0, 29};
    vecs[2] = '{16'h0200, 2, 5, 1, 0, 1'b0, 15};
    vecs[3] = '{16'hFFFF, 2, 0, 1, 0, 1'b0, 5};
    vecs[4] = '{16'h0300, 0, 0, 1, 0, 1'b0, 1};
    vecs[5] = '{16'h0400, 4, 0, 1, 0, 1'b1, 7};
    vecs[6] = '{16'h0500, 5, 1, 3, 2, 1'b0, 0};
    vecs[7] = '{16'h0600, 1, 2, 2, 0, 1'b0, 7};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Spurious return while idle
    @(negedge clk);
    mem_data_valid = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_data_valid = 1'b0;
    chk("spurious_err", 64'(protocol_err), 64'd1);
    @(negedge clk);
    chk("spurious_err_sticky", 64'(protocol_err), 64'd1);
    chk("spurious_dropped", 64'(out_valid), 64'd0);

    for (int i = 0; i < 8; i++) run_burst(vecs[i]);

    // Reset in the middle of a burst with one word buffered and a request pending
    @(negedge clk);
    base_addr = 16'h0700;
    num_words = 10'd8;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rst_pre_req", 64'(mem_req), 64'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_data_valid = 1'b1;
    mem_data = word_of(16'h0700);
    @(negedge clk);
    mem_data_valid = 1'b0;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    chk("rst_pre_req_held", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_data_valid = 1'b1;
    @(negedge clk);
    mem_data_valid = 1'b0;
    chk("late_return_err", 64'(protocol_err), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_read_client.md
Name: mem_read_client

Overview:
Initiator side of the controller's memory request/ack/data interface, instantiated inside the weight buffer and the decompressor.
- On a start pulse it reads a burst of NUM words from consecutive word addresses.
- Each word is a separate handshaked request, and several requests may be in flight at once.
- Returned words go into a small internal FIFO. The FIFO drains to the local consumer through a valid/ready stream.
- A credit count guarantees that returned data can never overflow the FIFO.

Parameters:
MEM_BANDWIDTH, 4, memory word width in bytes; the data width is MEM_BANDWIDTH*8.
ADDR_W, 16, memory word-address width; equals MEM_ADDR_SIZE.
LEN_W, 10, width of the burst-length field.
FIFO_DEPTH, 4, return FIFO entries; must be a power of two and at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a burst; ignored unless idle
base_addr  in  ADDR_W  first word address; sampled on start
num_words  in  LEN_W  number of words to read; sampled on start
busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
done  out  1  one-cycle pulse when the burst is fully delivered
mem_req  out  1  request to the controller; held until acked
mem_req_addr  out  ADDR_W  word address; stable while mem_req is high
mem_ack  in  1  one-cycle acceptance of the current request
mem_data  in  MEM_BANDWIDTH*8  returned word
mem_data_valid  in  1  mem_data is valid this cycle; data returns in request order
out_data  out  MEM_BANDWIDTH*8  FIFO head word
out_valid  out  1  FIFO is not empty
out_ready  in  1  consumer accepts the word when out_valid && out_ready
protocol_err  out  1  sticky error flag; cleared only by reset or an accepted start

Behaviour:
- Reset: state=IDLE; all counters and pointers cleared.
- Output reset values: busy, done, mem_req, out_valid and protocol_err are 0; mem_req_addr and out_data are 0.
- Registers:
  - base (latched base_addr);
  - total (latched num_words);
  - issued (LEN_W bits): requests acked so far;
  - outstanding (clog2(FIFO_DEPTH)+1 bits): acked requests whose data has not yet returned;
  - FIFO count, read pointer and write pointer.
- State machine, state IDLE:
  - start with num_words!=0: latch inputs, clear issued, clear protocol_err, go to REQ.
  - start with num_words==0: go to DONE.
  - start in any other state: ignored; no effect.
- State machine, state REQ:
  - mem_req = (issued<total) && (outstanding+fifo_count < FIFO_DEPTH).
  - mem_req_addr = base+issued, modulo 2^ADDR_W; the address wraps and no error is raised.
  - On mem_req&&mem_ack: issued++ and outstanding++.
  - When issued==total (counter value after update), go to DRAIN.
  - Once raised, mem_req stays high until acked. Credit cannot shrink while waiting, because outstanding only grows on ack.
  - mem_ack while mem_req==0 is ignored.
- State machine, state DRAIN:
  - mem_req=0.
  - Go to DONE when outstanding==0 and the FIFO is empty, including any pop happening that cycle.
- State machine, state DONE:
  - done=1 for exactly one cycle, then go to IDLE.
- Return path:
  - On mem_data_valid with outstanding>0: write mem_data into the FIFO and decrement outstanding.
  - If an ack happens in the same cycle, outstanding is unchanged.
  - mem_data_valid with outstanding==0, or in IDLE or DONE: the data is dropped and protocol_err is set.
- FIFO:
  - Write and read in the same cycle are both performed and the count is unchanged, including when the FIFO is full.
  - A push at cycle M is visible on out_valid/out_data at M+1 (registered storage, head read combinationally).
  - out_data holds its value while out_valid && !out_ready.
  - Overflow is impossible by the credit rule; there is no drop path.
- Latency:
  - start at cycle N: earliest mem_req at N+1.
  - Back-to-back acks allow one request per cycle while credit lasts.
  - Last word popped at cycle P with no outstanding requests: done at P+1.
- Reset mid-burst: immediate return to IDLE, the FIFO is flushed, mem_req drops asynchronously. Late returns after reset set protocol_err.

Test Plan:
- Zero-latency burst:
  - Stimulus: base=0x0010, num=3; controller acks every request the same cycle; data_valid one cycle after each ack; out_ready=1.
  - Required: addresses 0x0010, 0x0011, 0x0012 on consecutive cycles; out words in order; done exactly once; busy low afterwards.
- Credit stall:
  - Stimulus: FIFO_DEPTH=4, num=8, out_ready=0, immediate ack and return.
  - Required: exactly 4 acks, then mem_req=0; out_valid stays 1 without loss.
  - Then raise out_ready: the remaining 4 are requested; 8 words delivered in address order.
- Request hold:
  - Stimulus: ack delayed by 5 cycles.
  - Required: mem_req and mem_req_addr stable for all 5 cycles; exactly one issue per ack.
- Simultaneous events:
  - Stimulus: ack and data_valid in the same cycle, and push and pop on a full FIFO.
  - Required: outstanding and FIFO count unchanged; no word duplicated or lost.
- Boundaries:
  - base=0xFFFF, num=2: addresses 0xFFFF then 0x0000.
  - num=0: done at N+1 with mem_req never asserted.
  - start while busy: ignored.
- Error and reset:
  - Spurious data_valid in IDLE: protocol_err=1, which clears on the next accepted start.
  - rst_n asserted mid-burst: all outputs return to their reset values immediately.
